// File: rtl/pe_array_ws_db.sv
// Weight-stationary systolic MAC array with a shadow/active weight bank, internal input skew
// and output deskew, and a drain-then-swap controller gating activation intake.
module pe_array_ws_db #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter bit          SAT_EN     = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       w_load_valid_i,
  input  logic [DATA_WIDTH*COLS-1:0] w_load_data_i,
  output logic                       w_load_ready_o,
  input  logic                       w_swap_i,
  output logic                       weights_valid_o,
  input  logic                       act_valid_i,
  output logic                       act_ready_o,
  input  logic [DATA_WIDTH*ROWS-1:0] act_in_i,
  input  logic [ACC_WIDTH*COLS-1:0]  sum_in_i,
  output logic                       sum_valid_o,
  output logic [ACC_WIDTH*COLS-1:0]  sum_out_o
);

  localparam int unsigned Lat   = ROWS + COLS - 1;
  localparam int unsigned CntW  = $clog2(Lat + 2);
  localparam int unsigned BeatW = $clog2(ROWS);
  localparam int unsigned PW    = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {StLoad, StFull, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  logic [CntW-1:0]        inflight_q, inflight_d;
  logic                   wvalid_q, wvalid_d;
  logic                   swap_now, load_fire, act_fire;

  logic signed [DATA_WIDTH-1:0] shadow_q [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] active_q [ROWS][COLS];

  // Controller
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    wvalid_d       = wvalid_q;
    w_load_ready_o = 1'b0;
    act_ready_o    = 1'b1;
    swap_now       = 1'b0;
    unique case (state_q)
      StLoad: begin
        w_load_ready_o = 1'b1;
        if (w_load_valid_i) begin
          if (beat_q == BeatW'(ROWS - 1)) state_d = StFull;
          else                            beat_d  = beat_q + 1'b1;
        end
      end
      StFull: begin
        if (w_swap_i) state_d = StDrain;
      end
      StDrain: begin
        act_ready_o = 1'b0;
        if (inflight_q == '0) begin
          swap_now = 1'b1;
          wvalid_d = 1'b1;
          beat_d   = '0;
          state_d  = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign load_fire       = w_load_valid_i && w_load_ready_o;
  assign act_fire        = act_valid_i && act_ready_o;
  assign weights_valid_o = wvalid_q;

  always_comb begin
    inflight_d = inflight_q;
    case ({act_fire, sum_valid_o})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StLoad;
      beat_q     <= '0;
      inflight_q <= '0;
      wvalid_q   <= 1'b0;
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      wvalid_q   <= wvalid_d;
      if (load_fire) begin
        for (int c = 0; c < COLS; c++) begin
          shadow_q[0][c] <= w_load_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int r = 1; r < ROWS; r++) shadow_q[r] <= shadow_q[r-1];
      end
      if (swap_now) active_q <= shadow_q;
    end
  end

  // Datapath
  function automatic logic signed [ACC_WIDTH-1:0] mac(input logic signed [ACC_WIDTH-1:0]  ps,
                                                     input logic signed [DATA_WIDTH-1:0] a,
                                                     input logic signed [DATA_WIDTH-1:0] w);
    logic signed [PW-1:0]      prod;
    logic signed [ACC_WIDTH:0] wide;
    prod = PW'(a) * PW'(w);
    wide = $signed({ps[ACC_WIDTH-1], ps}) +
           $signed({{(ACC_WIDTH + 1 - PW){prod[PW-1]}}, prod});
    // A carry into the spare top bit that disagrees with the sign bit marks overflow.
    if (SAT_EN && (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])) begin
      return wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return wide[ACC_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] act_skew [ROWS];
  logic signed [ACC_WIDTH-1:0]  sum_skew [COLS];
  logic signed [ACC_WIDTH-1:0]  dsk      [COLS];
  logic signed [DATA_WIDTH-1:0] a_in     [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  ps_in    [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  pe_d     [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] a_q      [ROWS][COLS-1];
  logic signed [ACC_WIDTH-1:0]  p_q      [ROWS][COLS];
  logic [Lat:0]                 vld_q;
  logic [ACC_WIDTH*COLS-1:0]    sum_out_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_act_skew
    if (r == 0) begin : g_pass
      assign act_skew[r] = act_in_i[0 +: DATA_WIDTH];
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] dly_q [r];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          dly_q <= '{default: '0};
        end else begin
          dly_q[0] <= act_in_i[r*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < r; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign act_skew[r] = dly_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == 0) begin : g_pass_in
      assign sum_skew[c] = sum_in_i[0 +: ACC_WIDTH];
    end else begin : g_dly_in
      logic signed [ACC_WIDTH-1:0] dly_q [c];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          dly_q <= '{default: '0};
        end else begin
          dly_q[0] <= sum_in_i[c*ACC_WIDTH +: ACC_WIDTH];
          for (int i = 1; i < c; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign sum_skew[c] = dly_q[c-1];
    end

    if (c == COLS - 1) begin : g_pass_out
      assign dsk[c] = p_q[ROWS-1][c];
    end else begin : g_dly_out
      localparam int unsigned D = COLS - 1 - c;
      logic signed [ACC_WIDTH-1:0] dly_q [D];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          dly_q <= '{default: '0};
        end else begin
          dly_q[0] <= p_q[ROWS-1][c];
          for (int i = 1; i < int'(D); i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign dsk[c] = dly_q[D-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      if (c == 0) begin : g_a_edge
        assign a_in[r][c] = act_skew[r];
      end else begin : g_a_int
        assign a_in[r][c] = a_q[r][c-1];
      end
      if (r == 0) begin : g_p_edge
        assign ps_in[r][c] = sum_skew[c];
      end else begin : g_p_int
        assign ps_in[r][c] = p_q[r-1][c];
      end
      assign pe_d[r][c] = mac(ps_in[r][c], a_in[r][c], active_q[r][c]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q       <= '{default: '0};
      p_q       <= '{default: '0};
      vld_q     <= '0;
      sum_out_q <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          p_q[r][c] <= pe_d[r][c];
          if (c < COLS - 1) a_q[r][c] <= a_in[r][c];
        end
      end
      vld_q <= {vld_q[Lat-1:0], act_fire};
      // Deskewed columns line up one cycle before the result register.
      if (vld_q[Lat-1]) begin
        for (int c = 0; c < COLS; c++) sum_out_q[c*ACC_WIDTH +: ACC_WIDTH] <= dsk[c];
      end
    end
  end

  assign sum_valid_o = vld_q[Lat];
  assign sum_out_o   = sum_out_q;

endmodule

// File: tb/tb_pe_array_ws_db.sv
// Directed bench for pe_array_ws_db: 2x2 wrap array plus 16-bit saturating and wrapping copies
// sharing the same control stimulus.
module tb_pe_array_ws_db;

  logic        clk, rst_n;
  logic        w_load_valid, w_swap, act_valid;
  logic [15:0] w_load_data, act_in;
  logic [39:0] sum_in;
  logic [31:0] sum_in16;

  logic        m_wr, m_wv, m_ar, m_sv;
  logic [39:0] m_so;
  logic        s_wr, s_wv, s_ar, s_sv;
  logic [31:0] s_so;
  logic        w_wr, w_wv, w_ar, w_sv;
  logic [31:0] w_so;

  int checks = 0;
  int fails  = 0;

  pe_array_ws_db #(.DATA_WIDTH(8), .ROWS(2), .COLS(2), .ACC_WIDTH(20), .SAT_EN(1'b0)) u_main (
    .clk_i(clk), .rst_ni(rst_n), .w_load_valid_i(w_load_valid), .w_load_data_i(w_load_data),
    .w_load_ready_o(m_wr), .w_swap_i(w_swap), .weights_valid_o(m_wv), .act_valid_i(act_valid),
    .act_ready_o(m_ar), .act_in_i(act_in), .sum_in_i(sum_in), .sum_valid_o(m_sv),
    .sum_out_o(m_so)
  );

  pe_array_ws_db #(.DATA_WIDTH(8), .ROWS(2), .COLS(2), .ACC_WIDTH(16), .SAT_EN(1'b1)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .w_load_valid_i(w_load_valid), .w_load_data_i(w_load_data),
    .w_load_ready_o(s_wr), .w_swap_i(w_swap), .weights_valid_o(s_wv), .act_valid_i(act_valid),
    .act_ready_o(s_ar), .act_in_i(act_in), .sum_in_i(sum_in16), .sum_valid_o(s_sv),
    .sum_out_o(s_so)
  );

  pe_array_ws_db #(.DATA_WIDTH(8), .ROWS(2), .COLS(2), .ACC_WIDTH(16), .SAT_EN(1'b0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .w_load_valid_i(w_load_valid), .w_load_data_i(w_load_data),
    .w_load_ready_o(w_wr), .w_swap_i(w_swap), .weights_valid_o(w_wv), .act_valid_i(act_valid),
    .act_ready_o(w_ar), .act_in_i(act_in), .sum_in_i(sum_in16), .sum_valid_o(w_sv),
    .sum_out_o(w_so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [63:0] mcol(input int c);
    return $signed(m_so[c*20 +: 20]);
  endfunction

  function automatic logic signed [63:0] scol(input int c);
    return $signed(s_so[c*16 +: 16]);
  endfunction

  function automatic logic signed [63:0] wcol(input int c);
    return $signed(w_so[c*16 +: 16]);
  endfunction

  // Counts edges after the transfer edge until sum_valid rises, bounded.
  task automatic wait_result(input string tag);
    int lat = 0;
    while (m_sv !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check(tag, lat, 3);
  endtask

  initial begin
    int seen;
    rst_n = 1'b1; w_load_valid = 0; w_swap = 0; act_valid = 0;
    w_load_data = '0; act_in = '0; sum_in = '0; sum_in16 = '0;

    // Asynchronous reset, before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_sum_valid", m_sv, 0);
    check("rst_weights_valid", m_wv, 0);
    check("rst_w_load_ready", m_wr, 1);
    check("rst_act_ready", m_ar, 1);
    check("rst_sum_out", m_so, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Swap request in load state is ignored
    w_swap = 1; tick(); w_swap = 0;
    check("swap_in_load_act_ready", m_ar, 1);
    check("swap_in_load_wready", m_wr, 1);
    check("swap_in_load_wvalid", m_wv, 0);

    // Load weights A; swap coinciding with the last beat is ignored
    w_load_valid = 1; w_load_data = {8'd4, 8'd3}; tick();
    w_load_data = {8'd2, 8'd1}; w_swap = 1; tick();
    w_load_valid = 0; w_swap = 0; w_load_data = '0;
    check("full_wready", m_wr, 0);
    check("full_act_ready", m_ar, 1);
    tick();
    check("last_beat_swap_ignored", m_wv, 0);
    check("last_beat_swap_no_drain", m_ar, 1);
    w_swap = 1; tick(); w_swap = 0;
    check("drain_act_ready", m_ar, 0);
    check("drain_wvalid_pending", m_wv, 0);
    tick();
    check("swap_wvalid", m_wv, 1);
    check("swap_act_ready", m_ar, 1);
    check("swap_wready", m_wr, 1);

    // Basic MAC
    act_valid = 1; act_in = {8'd6, 8'd5}; sum_in = '0; tick();
    act_valid = 0; act_in = '0;
    wait_result("basic_latency");
    check("basic_col0", mcol(0), 23);
    check("basic_col1", mcol(1), 34);
    tick();
    check("basic_valid_pulse", m_sv, 0);
    check("basic_hold_col0", mcol(0), 23);

    // Signed activation with initial partial sum
    act_valid = 1; act_in = {8'd0, 8'hFF}; sum_in = {20'd0, 20'd10}; tick();
    act_valid = 0; act_in = '0; sum_in = '0;
    wait_result("signed_latency");
    check("signed_col0", mcol(0), 9);
    check("signed_col1", mcol(1), -2);

    // Stream on A while loading B; swap requested mid-stream
    act_valid = 1; act_in = {8'd1, 8'd1};
    w_load_valid = 1; w_load_data = {8'd0, 8'd2}; tick();
    act_in = {8'd0, 8'd2}; w_load_data = {8'd1, 8'd0}; tick();
    w_load_valid = 0; w_load_data = '0; act_in = {8'd2, 8'd0}; w_swap = 1; tick();
    w_swap = 0; act_in = {8'd1, 8'd1};
    check("ovl_drain_ready", m_ar, 0);
    tick();
    check("ovl_r1_valid", m_sv, 1);
    check("ovl_r1_col0", mcol(0), 4);
    check("ovl_r1_col1", mcol(1), 6);
    tick();
    check("ovl_r2_col0", mcol(0), 2);
    check("ovl_r2_col1", mcol(1), 4);
    tick();
    check("ovl_r3_valid", m_sv, 1);
    check("ovl_r3_col0", mcol(0), 6);
    check("ovl_r3_col1", mcol(1), 8);
    check("ovl_r3_ready", m_ar, 0);
    tick();
    check("ovl_after_valid", m_sv, 0);
    check("ovl_wait_inflight", m_ar, 0);
    tick();
    check("ovl_swapped_ready", m_ar, 1);
    tick();
    act_valid = 0; act_in = '0;
    wait_result("ovl_b_latency");
    check("ovl_b_col0", mcol(0), 2);
    check("ovl_b_col1", mcol(1), 1);

    // Saturation vs wrap with W[0][0]=127 only
    w_load_valid = 1; w_load_data = '0; tick();
    w_load_data = {8'd0, 8'd127}; tick();
    w_load_valid = 0; w_load_data = '0; w_swap = 1; tick();
    w_swap = 0; tick();
    check("sat_ready", m_ar, 1);
    act_valid = 1; act_in = {8'd0, 8'd127}; sum_in16 = {16'd0, 16'h7FFF}; tick();
    act_valid = 0; act_in = '0; sum_in16 = '0;
    wait_result("sat_latency");
    check("sat_col0", scol(0), 32767);
    check("sat_col1", scol(1), 0);
    check("wrap_col0", wcol(0), -16640);
    check("main_col0_127sq", mcol(0), 16129);
    check("sat_valid_aligned", s_sv, 1);

    // Reset with two tokens in flight
    act_valid = 1; act_in = {8'd1, 8'd1}; tick(); tick();
    act_valid = 0; act_in = '0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum_valid", m_sv, 0);
    check("mid_rst_wvalid", m_wv, 0);
    check("mid_rst_act_ready", m_ar, 1);
    check("mid_rst_sum_out", m_so, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      if (m_sv === 1'b1) seen++;
    end
    check("mid_rst_no_results", seen, 0);
    check("mid_rst_load_state", m_wr, 1);
    check("mid_rst_wvalid_after", m_wv, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
